// File: rtl/us_udp_buf_pkg.sv
// Shared definitions for the UDP receive packet buffer.
//   ENTRY_W      : width of one stored beat, laid out as {tlast, tkeep, tdata}
//   *_LSB/_MSB   : bit positions of the fields inside a stored beat
//   ptr_diff()   : modular difference of two buffer pointers; callers truncate
//                  the result to their pointer width, which gives the
//                  wrap-around distance directly.
package us_udp_buf_pkg;

   localparam int DATA_W   = 64;
   localparam int KEEP_W   = 8;
   localparam int ENTRY_W  = 73;

   localparam int DATA_LSB = 0;
   localparam int DATA_MSB = 63;
   localparam int KEEP_LSB = 64;
   localparam int KEEP_MSB = 71;
   localparam int LAST_BIT = 72;

   function automatic logic [31:0] ptr_diff(input logic [31:0] a,
                                            input logic [31:0] b);
      return a - b;
   endfunction

endpackage

// File: rtl/us_sdp_ram.sv
// Simple dual-port RAM: one write port, one synchronous read port.
//   clk   : clock
//   we    : write enable, waddr/wdata written on the rising edge
//   re    : read enable; rdata updates only when re=1 and otherwise holds,
//           so a fetched word can wait here until the consumer takes it
//   raddr : read address
//   rdata : registered read data
// The array has no reset.
module us_sdp_ram #(
   parameter int ADDR_W = 9,
   parameter int DATA_W = 73
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              re,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [2**ADDR_W];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      if (re) rdata <= mem[raddr];
   end

endmodule

// File: rtl/us_udp_rx_pkt_buf.sv
// Store-and-forward buffer behind the UDP receive path.
// Inputs : rx_axis_aclk, rx_axis_areset (sync, active high), in_axis_* beat
//          stream with no backpressure, out_axis_tready from the user.
// Outputs: out_axis_* AXI-Stream (only good frames, tuser always 0),
//          buf_level (beats held, committed plus in progress, including the
//          beats already fetched into the output pipeline but not accepted),
//          frame_ok_cnt / drop_err_cnt / drop_ovf_cnt statistics.
//
// Handshake: a beat transfers on a rising edge where out_axis_tvalid and
// out_axis_tready are both 1. Once tvalid is raised, tdata/tkeep/tlast stay
// stable until that transfer; tvalid never depends combinationally on tready.
//
// Read pipeline: fetch_ptr addresses the RAM, the RAM output word waits there
// (rd_pend) until the output register is free, and rd_ptr advances only when
// the user accepts a beat. Fullness is measured against rd_ptr, so nothing in
// the pipeline can be overwritten by the writer.
module us_udp_rx_pkt_buf
   import us_udp_buf_pkg::*;
#(
   parameter int DEPTH_LOG2 = 9,
   parameter int CNT_W      = 32
) (
   input  logic                  rx_axis_aclk,
   input  logic                  rx_axis_areset,
   input  logic [63:0]           in_axis_tdata,
   input  logic [7:0]            in_axis_tkeep,
   input  logic                  in_axis_tvalid,
   input  logic                  in_axis_tlast,
   input  logic                  in_axis_tuser,
   output logic [63:0]           out_axis_tdata,
   output logic [7:0]            out_axis_tkeep,
   output logic                  out_axis_tvalid,
   output logic                  out_axis_tlast,
   output logic                  out_axis_tuser,
   input  logic                  out_axis_tready,
   output logic [DEPTH_LOG2:0]   buf_level,
   output logic [CNT_W-1:0]      frame_ok_cnt,
   output logic [CNT_W-1:0]      drop_err_cnt,
   output logic [CNT_W-1:0]      drop_ovf_cnt
);

   localparam int PTR_W = DEPTH_LOG2 + 1;
   localparam logic [PTR_W-1:0] FULL_LEVEL = {1'b1, {DEPTH_LOG2{1'b0}}};
   localparam logic [PTR_W-1:0] PTR_ONE    = {{DEPTH_LOG2{1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [PTR_W-1:0]   wr_ptr, start_ptr, commit_ptr, fetch_ptr, rd_ptr;
   logic               ovf, sync_q, rd_pend;
   logic [PTR_W-1:0]   level;
   logic               full, beat, wr_en, issue, load, accept;
   logic [ENTRY_W-1:0] ram_wdata, ram_rdata;

   always_comb begin
      level     = PTR_W'(ptr_diff(32'(wr_ptr), 32'(rd_ptr)));
      full      = (level == FULL_LEVEL);
      beat      = in_axis_tvalid && sync_q;
      wr_en     = beat && !full && !ovf;
      ram_wdata = {in_axis_tlast, in_axis_tkeep, in_axis_tdata};
      accept    = out_axis_tvalid && out_axis_tready;
      // The output register can take a new word this cycle.
      load      = rd_pend && (!out_axis_tvalid || out_axis_tready);
      // A new fetch only when the word already in the RAM output (if any)
      // moves into the output register on the same edge.
      issue     = (fetch_ptr != commit_ptr) && (!out_axis_tvalid || out_axis_tready);
   end

   assign buf_level      = level;
   assign out_axis_tuser = 1'b0;

   us_sdp_ram #(
      .ADDR_W (DEPTH_LOG2),
      .DATA_W (ENTRY_W)
   ) u_ram (
      .clk   (rx_axis_aclk),
      .we    (wr_en),
      .waddr (wr_ptr[DEPTH_LOG2-1:0]),
      .wdata (ram_wdata),
      .re    (issue),
      .raddr (fetch_ptr[DEPTH_LOG2-1:0]),
      .rdata (ram_rdata)
   );

   // Write side: frame accumulation, commit and rollback.
   always_ff @(posedge rx_axis_aclk) begin
      if (rx_axis_areset) begin
         wr_ptr       <= '0;
         start_ptr    <= '0;
         commit_ptr   <= '0;
         ovf          <= 1'b0;
         sync_q       <= 1'b0;
         frame_ok_cnt <= '0;
         drop_err_cnt <= '0;
         drop_ovf_cnt <= '0;
      end else if (in_axis_tvalid && !sync_q) begin
         // Frame in flight at reset is skipped; the next frame starts clean.
         if (in_axis_tlast) sync_q <= 1'b1;
      end else if (beat) begin
         if (in_axis_tlast) begin
            if (ovf || full) begin
               wr_ptr       <= start_ptr;
               drop_ovf_cnt <= drop_ovf_cnt + CNT_ONE;
               ovf          <= 1'b0;
            end else if (in_axis_tuser) begin
               wr_ptr       <= start_ptr;
               drop_err_cnt <= drop_err_cnt + CNT_ONE;
            end else begin
               wr_ptr       <= wr_ptr + PTR_ONE;
               commit_ptr   <= wr_ptr + PTR_ONE;
               start_ptr    <= wr_ptr + PTR_ONE;
               frame_ok_cnt <= frame_ok_cnt + CNT_ONE;
            end
         end else if (full) begin
            ovf <= 1'b1;
         end else if (!ovf) begin
            wr_ptr <= wr_ptr + PTR_ONE;
         end
      end
   end

   // Read side: fetch, RAM output hold, output register.
   always_ff @(posedge rx_axis_aclk) begin
      if (rx_axis_areset) begin
         fetch_ptr       <= '0;
         rd_ptr          <= '0;
         rd_pend         <= 1'b0;
         out_axis_tvalid <= 1'b0;
         out_axis_tlast  <= 1'b0;
         out_axis_tdata  <= '0;
         out_axis_tkeep  <= '0;
      end else begin
         if (issue) fetch_ptr <= fetch_ptr + PTR_ONE;
         if (accept) rd_ptr <= rd_ptr + PTR_ONE;
         rd_pend <= issue || (rd_pend && !load);
         if (load) begin
            out_axis_tvalid <= 1'b1;
            out_axis_tdata  <= ram_rdata[DATA_MSB:DATA_LSB];
            out_axis_tkeep  <= ram_rdata[KEEP_MSB:KEEP_LSB];
            out_axis_tlast  <= ram_rdata[LAST_BIT];
         end else if (out_axis_tready) begin
            out_axis_tvalid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_us_udp_rx_pkt_buf.sv
// Bench for us_udp_rx_pkt_buf: instance 0 uses the default depth (512 beats),
// instance 1 uses a 16-beat buffer for the overflow cases.
module tb_us_udp_rx_pkt_buf;

   logic        clk = 1'b0;
   logic        rst       [2];
   logic [63:0] in_tdata  [2];
   logic [7:0]  in_tkeep  [2];
   logic        in_tvalid [2];
   logic        in_tlast  [2];
   logic        in_tuser  [2];
   logic [63:0] out_tdata [2];
   logic [7:0]  out_tkeep [2];
   logic        out_tvalid[2];
   logic        out_tlast [2];
   logic        out_tuser [2];
   logic        out_tready[2];
   logic [31:0] ok_cnt    [2];
   logic [31:0] err_cnt   [2];
   logic [31:0] ovf_cnt   [2];
   logic [9:0]  lvl_big;
   logic [4:0]  lvl_small;

   logic [72:0] exp_q0[$];
   logic [72:0] exp_q1[$];
   int          pops[2];
   int          tests = 0;
   int          fails = 0;

   always #5 clk = ~clk;

   us_udp_rx_pkt_buf #(.DEPTH_LOG2(9), .CNT_W(32)) u_big (
      .rx_axis_aclk(clk), .rx_axis_areset(rst[0]),
      .in_axis_tdata(in_tdata[0]), .in_axis_tkeep(in_tkeep[0]),
      .in_axis_tvalid(in_tvalid[0]), .in_axis_tlast(in_tlast[0]),
      .in_axis_tuser(in_tuser[0]),
      .out_axis_tdata(out_tdata[0]), .out_axis_tkeep(out_tkeep[0]),
      .out_axis_tvalid(out_tvalid[0]), .out_axis_tlast(out_tlast[0]),
      .out_axis_tuser(out_tuser[0]), .out_axis_tready(out_tready[0]),
      .buf_level(lvl_big), .frame_ok_cnt(ok_cnt[0]),
      .drop_err_cnt(err_cnt[0]), .drop_ovf_cnt(ovf_cnt[0])
   );

   us_udp_rx_pkt_buf #(.DEPTH_LOG2(4), .CNT_W(32)) u_small (
      .rx_axis_aclk(clk), .rx_axis_areset(rst[1]),
      .in_axis_tdata(in_tdata[1]), .in_axis_tkeep(in_tkeep[1]),
      .in_axis_tvalid(in_tvalid[1]), .in_axis_tlast(in_tlast[1]),
      .in_axis_tuser(in_tuser[1]),
      .out_axis_tdata(out_tdata[1]), .out_axis_tkeep(out_tkeep[1]),
      .out_axis_tvalid(out_tvalid[1]), .out_axis_tlast(out_tlast[1]),
      .out_axis_tuser(out_tuser[1]), .out_axis_tready(out_tready[1]),
      .buf_level(lvl_small), .frame_ok_cnt(ok_cnt[1]),
      .drop_err_cnt(err_cnt[1]), .drop_ovf_cnt(ovf_cnt[1])
   );

   function automatic void check(input string name, input logic [127:0] act,
                                 input logic [127:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endfunction

   function automatic int level(input int d);
      return (d == 0) ? int'(lvl_big) : int'(lvl_small);
   endfunction

   function automatic int qsize(input int d);
      return (d == 0) ? exp_q0.size() : exp_q1.size();
   endfunction

   function automatic void push(input int d, input logic [72:0] e);
      if (d == 0) exp_q0.push_back(e);
      else        exp_q1.push_back(e);
   endfunction

   // ---------------- monitor / scoreboard ----------------
   always @(negedge clk) begin
      for (int d = 0; d < 2; d++) begin
         if (!rst[d] && out_tvalid[d] && out_tready[d]) begin
            logic [72:0] got;
            logic [72:0] exp;
            got = {out_tlast[d], out_tkeep[d], out_tdata[d]};
            check($sformatf("out_tuser_%0d", d), 128'(out_tuser[d]), 128'(0));
            if (qsize(d) == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_beat_%0d: got %0h, expected no beat", d, got);
            end else begin
               exp = (d == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
               check($sformatf("out_beat_%0d", d), 128'(got), 128'(exp));
            end
            pops[d]++;
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic drive_beat(input int d, input logic [63:0] data,
                             input logic [7:0] keep, input logic last,
                             input logic user);
      @(posedge clk); #1;
      in_tvalid[d] = 1'b1;
      in_tdata[d]  = data;
      in_tkeep[d]  = keep;
      in_tlast[d]  = last;
      in_tuser[d]  = user;
   endtask

   task automatic idle(input int d, input int n);
      repeat (n) begin
         @(posedge clk); #1;
         in_tvalid[d] = 1'b0;
         in_tlast[d]  = 1'b0;
         in_tuser[d]  = 1'b0;
      end
   endtask

   // tuser is driven as the opposite of the frame flag on non-last beats,
   // since only the tlast beat's tuser is meaningful.
   task automatic send_frame(input int d, input int n, input logic [63:0] base,
                             input logic [7:0] last_keep, input logic user,
                             input logic expect_out);
      for (int i = 0; i < n; i++) begin
         logic       last;
         logic [7:0] k;
         last = (i == n - 1);
         k    = last ? last_keep : 8'hFF;
         drive_beat(d, base + 64'(i), k, last, last ? user : !user);
         if (expect_out) push(d, {last, k, base + 64'(i)});
      end
   endtask

   task automatic drain(input int d, input string name);
      int n;
      n = 0;
      while ((qsize(d) != 0 || out_tvalid[d]) && n < 500) begin
         @(negedge clk);
         n++;
      end
      check(name, 128'(n < 500), 128'(1));
   endtask

   task automatic check_counts(input int d, input string tag, input int ok,
                               input int err, input int ovf, input int lvl);
      @(negedge clk);
      check({tag, "_ok"},  128'(ok_cnt[d]),  128'(ok));
      check({tag, "_err"}, 128'(err_cnt[d]), 128'(err));
      check({tag, "_ovf"}, 128'(ovf_cnt[d]), 128'(ovf));
      check({tag, "_lvl"}, 128'(level(d)),   128'(lvl));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
      $fatal(1, "watchdog");
   end

   // ---------------- main sequence ----------------
   initial begin
      int lat;
      int cyc;
      int base_pops;
      for (int d = 0; d < 2; d++) begin
         rst[d] = 1'b1; in_tvalid[d] = 1'b0; in_tdata[d] = '0; in_tkeep[d] = '0;
         in_tlast[d] = 1'b0; in_tuser[d] = 1'b0; out_tready[d] = 1'b1;
         pops[d] = 0;
      end
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_tvalid", 128'(out_tvalid[0]), 128'(0));
      check("rst_tlast",  128'(out_tlast[0]),  128'(0));
      check("rst_tdata",  128'(out_tdata[0]),  128'(0));
      check("rst_tkeep",  128'(out_tkeep[0]),  128'(0));
      check("rst_tuser",  128'(out_tuser[0]),  128'(0));
      check_counts(0, "rst", 0, 0, 0, 0);
      @(posedge clk); #1;
      rst[0] = 1'b0; rst[1] = 1'b0;

      // Resync dummy, then a 4-beat good frame and its latency.
      send_frame(0, 1, 64'hDEAD, 8'hFF, 1'b0, 1'b0);
      idle(0, 2);
      send_frame(0, 4, 64'h1000, 8'h0F, 1'b0, 1'b1);
      idle(0, 1);
      lat = 0;
      while (lat < 20) begin
         @(negedge clk);
         if (out_tvalid[0]) break;
         lat++;
      end
      check("latency", 128'(lat), 128'(2));
      drain(0, "drain_good");
      check_counts(0, "good", 1, 0, 0, 0);

      // Error drop followed by a good frame.
      send_frame(0, 3, 64'h2000, 8'hFF, 1'b1, 1'b0);
      idle(0, 1);
      send_frame(0, 2, 64'h2100, 8'h03, 1'b0, 1'b1);
      idle(0, 1);
      drain(0, "drain_err");
      check_counts(0, "err", 2, 1, 0, 0);

      // Backpressure: five back-to-back 8-beat frames with tready low.
      out_tready[0] = 1'b0;
      for (int f = 0; f < 5; f++)
         send_frame(0, 8, 64'h3000 + 64'(f) * 64'h100, 8'hFF, 1'b0, 1'b1);
      idle(0, 4);
      check_counts(0, "bp", 7, 1, 0, 40);
      check("bp_valid",  128'(out_tvalid[0]), 128'(1));
      check("bp_data_a", 128'(out_tdata[0]),  128'(64'h3000));
      repeat (3) @(negedge clk);
      check("bp_data_b", 128'(out_tdata[0]),  128'(64'h3000));
      @(posedge clk); #1;
      out_tready[0] = 1'b1;
      cyc = 0;
      while (exp_q0.size() != 0 && cyc < 200) begin
         @(posedge clk); #2;
         cyc++;
      end
      check("bp_drain_cycles", 128'(cyc), 128'(40));
      drain(0, "drain_bp");
      check_counts(0, "bp_end", 7, 1, 0, 0);

      // Small buffer: resync, then overflow of the second 10-beat frame.
      send_frame(1, 1, 64'hBEEF, 8'hFF, 1'b0, 1'b0);
      idle(1, 2);
      out_tready[1] = 1'b0;
      send_frame(1, 10, 64'h4000, 8'hFF, 1'b0, 1'b1);
      idle(1, 2);
      send_frame(1, 10, 64'h4100, 8'h01, 1'b0, 1'b0);
      idle(1, 3);
      check_counts(1, "ovf", 1, 0, 1, 10);
      base_pops = pops[1];
      out_tready[1] = 1'b1;
      drain(1, "drain_ovf");
      check("ovf_beats_out", 128'(pops[1] - base_pops), 128'(10));
      check_counts(1, "ovf_end", 1, 0, 1, 0);

      // Boundary: a frame of exactly the buffer size is kept.
      out_tready[1] = 1'b0;
      send_frame(1, 16, 64'h5000, 8'h7F, 1'b0, 1'b1);
      idle(1, 3);
      check_counts(1, "exact", 2, 0, 1, 16);
      out_tready[1] = 1'b1;
      drain(1, "drain_exact");

      // Oversized frame with tuser=1 counts as overflow only.
      send_frame(1, 20, 64'h6000, 8'hFF, 1'b1, 1'b0);
      idle(1, 3);
      check_counts(1, "ovf_user", 2, 0, 2, 0);

      // Reset while a 6-beat frame is being emitted.
      base_pops = pops[0];
      send_frame(0, 6, 64'h7000, 8'hFF, 1'b0, 1'b1);
      idle(0, 1);
      cyc = 0;
      while (pops[0] < base_pops + 1 && cyc < 50) begin
         @(negedge clk);
         cyc++;
      end
      check("mid_reset_start", 128'(cyc < 50), 128'(1));
      @(posedge clk); #1;
      rst[0] = 1'b1;
      exp_q0.delete();
      @(posedge clk); #1;
      check("mid_reset_tvalid", 128'(out_tvalid[0]), 128'(0));
      check_counts(0, "mid_reset", 0, 0, 0, 0);
      @(posedge clk); #1;
      rst[0] = 1'b0;
      // First frame after reset only resynchronises.
      send_frame(0, 3, 64'h8000, 8'hFF, 1'b0, 1'b0);
      idle(0, 3);
      check_counts(0, "resync", 0, 0, 0, 0);
      check("resync_tvalid", 128'(out_tvalid[0]), 128'(0));
      send_frame(0, 2, 64'h9000, 8'h3F, 1'b0, 1'b1);
      idle(0, 1);
      drain(0, "drain_after_reset");
      check_counts(0, "after_reset", 1, 0, 0, 0);

      check("leftover_q0", 128'(exp_q0.size()), 128'(0));
      check("leftover_q1", 128'(exp_q1.size()), 128'(0));
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
